// File: rtl/usrt_rx_deser_if.sv
// ============================================================================
// Module   : usrt_rx_deser_if
// Brief    : Serial-side inputs and frame-side outputs of the USRT deserializer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface usrt_rx_deser_if #(
  parameter int DATA_BITS = 8
);
  logic                   sclk;
  logic                   rx;
  logic [1:0]             parity;
  logic [DATA_BITS+2:0]   frame;
  logic                   valid;
  logic                   frame_err;
  logic                   timeout;
  logic                   busy;

  modport master (
    output sclk, rx, parity,
    input  frame, valid, frame_err, timeout, busy
  );

  modport slave (
    input  sclk, rx, parity,
    output frame, valid, frame_err, timeout, busy
  );
endinterface

`default_nettype wire

// File: rtl/usrt_rx_deser.sv
// ============================================================================
// Module   : usrt_rx_deser
// Brief    : USRT receive deserializer, start/data/parity/stop -> parallel word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usrt_rx_deser #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  usrt_rx_deser_if.slave   bus
);
  localparam int FW    = DATA_BITS + 3;
  localparam int BIT_W = $clog2(DATA_BITS) + 1;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                 r_state, w_next_state;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_rx_sync;
  logic                   r_sclk_prev;
  logic [FW-1:0]          r_shift, r_frame;
  logic [BIT_W-1:0]       r_bitcnt;
  logic                   r_par_en;
  logic [CNT_W-1:0]       r_tmo_cnt;
  logic                   r_valid, r_frame_err, r_timeout;

  logic w_edge, w_bit, w_tmo_hit;
  logic w_start, w_data, w_par, w_stop, w_emit;

  // Rx idles high and Sclk low out of reset so no phantom edge or start bit appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_rx_sync   <= '1;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_rx_sync   <= {r_rx_sync[SYNC_STAGES-2:0], bus.rx};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge    = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign w_bit     = r_rx_sync[SYNC_STAGES-1];
  assign w_tmo_hit = (TIMEOUT_CYC != 0) && (r_state != S_IDLE) && !w_edge &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_data       = 1'b0;
    w_par        = 1'b0;
    w_stop       = 1'b0;
    w_emit       = 1'b0;
    case (r_state)
      S_IDLE: if (w_edge && !w_bit) begin
        w_start      = 1'b1;
        w_next_state = S_DATA;
      end
      S_DATA: if (w_edge) begin
        w_data = 1'b1;
        if (r_bitcnt == BIT_W'(DATA_BITS - 1))
          w_next_state = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_edge) begin
        w_par        = 1'b1;
        w_next_state = S_STOP;
      end
      S_STOP: if (w_edge) begin
        w_stop       = 1'b1;
        w_next_state = S_DONE;
      end
      S_DONE: begin
        w_emit       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_tmo_hit) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= '0;
      r_frame     <= '0;
      r_bitcnt    <= '0;
      r_par_en    <= 1'b0;
      r_tmo_cnt   <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_valid   <= w_emit;
      r_timeout <= w_tmo_hit;

      if (w_edge || r_state == S_IDLE || w_tmo_hit) r_tmo_cnt <= '0;
      else                                          r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);

      // Shift register starts cleared, so the parity slot reads 0 in no-parity mode.
      if (w_start) begin
        r_shift  <= '0;
        r_bitcnt <= '0;
        r_par_en <= (bus.parity == 2'b01) || (bus.parity == 2'b10);
      end
      if (w_data) begin
        r_shift[r_bitcnt + BIT_W'(1)] <= w_bit;
        r_bitcnt                      <= r_bitcnt + BIT_W'(1);
      end
      if (w_par)  r_shift[DATA_BITS+1] <= w_bit;
      if (w_stop) r_shift[FW-1]        <= w_bit;
      if (w_emit) begin
        r_frame     <= r_shift;
        r_frame_err <= ~r_shift[FW-1];
      end
    end
  end

  assign bus.frame     = r_frame;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.timeout   = r_timeout;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
